// File: rtl/clock_divider_pkg.sv
// Shared definitions for the clock divider and its scale-change controller.
package clock_divider_pkg;

  localparam int SCALE_W = 8;
  localparam logic [SCALE_W-1:0] DEFAULT_SCALE = 8'd1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TICK,
    DWELL
  } ctrl_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
  import clock_divider_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt
);

  logic [PTR_W:0] pos;
  logic           found;

  // ptr < NREQ and k < NREQ, so a single subtraction is enough for the wrap
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, ptr} + (PTR_W+1)'(k);
      if (pos >= (PTR_W+1)'(NREQ)) begin
        pos = pos - (PTR_W+1)'(NREQ);
      end
      if (!found && req[pos[PTR_W-1:0]]) begin
        gnt[pos[PTR_W-1:0]] = 1'b1;
        found               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_divider_ctrl.sv
// Arbitrates divide-ratio change requests and applies the winner only on the
// divider's terminal-count tick, then holds off further changes for a dwell.
module clock_divider_ctrl #(
  parameter int                 NREQ          = 4,
  parameter int                 SCALE_W       = clock_divider_pkg::SCALE_W,
  parameter int                 DWELL_W       = 16,
  parameter logic [SCALE_W-1:0] DEFAULT_SCALE = SCALE_W'(clock_divider_pkg::DEFAULT_SCALE)
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*SCALE_W-1:0] req_scale,
  input  logic [DWELL_W-1:0]      min_dwell,
  input  logic                    div_tick,
  output logic [SCALE_W-1:0]      scale_out,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         ack,
  output logic                    busy
);

  import clock_divider_pkg::*;

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  // A divide ratio of zero is meaningless to the divider; treat it as 1.
  function automatic logic [SCALE_W-1:0] legal_scale(input logic [SCALE_W-1:0] s);
    return (s == '0) ? SCALE_W'(1) : s;
  endfunction

  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] i);
    return (i == PTR_W'(NREQ-1)) ? '0 : i + PTR_W'(1);
  endfunction

  ctrl_state_t        state_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   who_q;
  logic [SCALE_W-1:0] scale_q;
  logic [SCALE_W-1:0] pend_q;
  logic [NREQ-1:0]    grant_q;
  logic [NREQ-1:0]    ack_q;
  logic [DWELL_W-1:0] dwell_q;

  logic [NREQ-1:0]    arb_gnt;
  logic [PTR_W-1:0]   win_idx_d;
  logic [SCALE_W-1:0] win_scale_d;
  logic [NREQ-1:0]    who_1h;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt)
  );

  always_comb begin
    win_idx_d   = '0;
    win_scale_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        win_idx_d   = PTR_W'(i);
        win_scale_d = req_scale[i*SCALE_W +: SCALE_W];
      end
    end
  end

  assign who_1h = {{(NREQ-1){1'b0}}, 1'b1} << who_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      who_q   <= '0;
      scale_q <= DEFAULT_SCALE;
      pend_q  <= DEFAULT_SCALE;
      grant_q <= '0;
      ack_q   <= '0;
      dwell_q <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            grant_q <= arb_gnt;
            who_q   <= win_idx_d;
            pend_q  <= legal_scale(win_scale_d);
            state_q <= WAIT_TICK;
          end
        end
        // Abort beats the shortcut, which beats the tick
        WAIT_TICK: begin
          if (!req[who_q]) begin
            grant_q <= '0;
            ptr_q   <= next_idx(who_q);
            state_q <= IDLE;
          end else if (pend_q == scale_q) begin
            ack_q   <= who_1h;
            grant_q <= '0;
            ptr_q   <= next_idx(who_q);
            state_q <= IDLE;
          end else if (div_tick) begin
            scale_q <= pend_q;
            ack_q   <= who_1h;
            grant_q <= '0;
            dwell_q <= min_dwell;
            state_q <= DWELL;
          end
        end
        DWELL: begin
          if (dwell_q == '0) begin
            ptr_q   <= next_idx(who_q);
            state_q <= IDLE;
          end else begin
            dwell_q <= dwell_q - DWELL_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign scale_out = scale_q;
  assign grant     = grant_q;
  assign ack       = ack_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/clock_divider_ctrl.md
Name: clock_divider_ctrl

Overview:
- Arbitrates and sequences scale changes for the shared `clock_divider` instance.
- Up to NREQ requesters each ask for a new divide ratio. The controller picks one round-robin and applies its ratio only at the divider's terminal-count boundary (`div_tick`), so `clk_out` never glitches.
- After each change it enforces a minimum dwell before the next change.
- Sits between the requesters and the divider's `scale` input, in the same clock domain as the divider.

Parameters:
- NREQ, 4, number of requesters (2..8)
- SCALE_W, 8, width of a scale value
- DWELL_W, 16, width of the dwell counter
- DEFAULT_SCALE, 8'd1, `scale_out` value after reset

Ports:
- clk_in  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- req  input  NREQ  per-requester change request, level
- req_scale  input  NREQ*SCALE_W  requested scale; requester i uses bits [i*SCALE_W +: SCALE_W]
- min_dwell  input  DWELL_W  minimum cycles between applied changes
- div_tick  input  1  one-cycle pulse at the divider's terminal count, i.e. the safe update point
- scale_out  output  SCALE_W  scale driven to the divider
- grant  output  NREQ  one-hot; held while a request is being serviced
- ack  output  NREQ  one-cycle pulse; marks the cycle in which the new scale becomes visible
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock (`clk_in`); reset is asynchronous and active-high (`rst`).
- Reset values: `scale_out`=DEFAULT_SCALE, `grant`=0, `ack`=0, `busy`=0, state=IDLE, round-robin pointer=0, dwell counter=0.
- State IDLE:
  - If any `req` bit is high, the arbiter picks the first set bit at or after the pointer, with wrap-around.
  - Next cycle: `grant`=one-hot of the winner, the winner's `req_scale` slice is latched into `pend_scale`, state=WAIT_TICK.
  - `div_tick` is ignored in IDLE.
- `pend_scale` rules:
  - A latched value of 0 is illegal and is coerced to 1.
  - `req_scale` is sampled only at grant; later changes are ignored.
- State WAIT_TICK:
  - If `req[granted]` drops: abort. Next cycle `grant`=0, no `ack`, `scale_out` unchanged, pointer=granted+1 mod NREQ, state=IDLE.
  - Else if `pend_scale` == `scale_out`: shortcut. Next cycle `ack[granted]`=1, `grant`=0, state=IDLE, pointer advances. No dwell and no tick wait.
  - Else if `div_tick`=1: next cycle `scale_out`=`pend_scale`, `ack[granted]`=1, `grant`=0, dwell counter loaded with `min_dwell`, state=DWELL.
  - Abort has priority over the shortcut and over `div_tick` in the same cycle.
- State DWELL:
  - Counter decrements each cycle; `req` inputs are ignored.
  - When the counter == 0: next state is IDLE and the pointer becomes granted+1 mod NREQ.
  - `min_dwell`=0 gives exactly one DWELL cycle.
- Latency: with `req` high in IDLE at cycle 0, `grant` is high at cycle 1. If `div_tick` arrives at cycle k≥1, `ack` and the new `scale_out` appear at cycle k+1.
- Requester contract: hold `req` until `ack`. A `req` still high after `ack` is a new request.
- Arbiter fairness: the pointer advances on ack and on abort only. No requester waits more than NREQ-1 services.
- Reset mid-operation: all outputs return to reset values immediately. The pending request is dropped without `ack`.
- `ack` and `grant` are never high in the same cycle. `ack` is never high for more than one bit.

Decomposition:
- Shared package `clock_divider_pkg`:
  - state enum `ctrl_state_t` {IDLE, WAIT_TICK, DWELL}
  - DEFAULT_SCALE constant
  - SCALE_W localparam, shared with `clock_divider`
- One sub-module: `rr_arbiter` (NREQ; inputs `req` and `ptr`; output one-hot `gnt`), purely combinational, pointer kept in the controller.

Test Plan:
- Reset and single change: reset; `req[0]`=1 with scale 8; `div_tick` at cycle 5 -> `grant`=0001 at cycle 1, `scale_out`=8 and `ack`=0001 at cycle 6, `busy` high cycles 1..6+dwell.
- Round-robin: `req`=1111 held with scales 2,3,4,5, `min_dwell`=2, `div_tick` every 3 cycles -> acks in order 0,1,2,3,0; `scale_out` sequence 2,3,4,5,2; at least 3 cycles from `ack` to next `grant`.
- Shortcut and zero coercion: `scale_out`=1; `req[2]` with scale 0 -> `ack[2]` the cycle after grant, no `div_tick` needed, `scale_out` stays 1, no DWELL.
- Abort: `req[1]` with scale 6 granted, dropped before any `div_tick` -> no `ack`, `scale_out` unchanged, next `req[1]`/`req[2]` contention grants 2.
- Priority race: `req[3]` drops in the same cycle `div_tick`=1 -> abort wins, no `ack`, `scale_out` unchanged.
- Async reset in DWELL: assert `rst` mid-count -> outputs immediately at reset values (`scale_out`=1), pointer 0, `req[0]` serviced first after release.
